// File: rtl/iiitb_jc_pkg.sv
// Shared types and constants for the Johnson-code receive checker.
// Reverse stepping is enabled with JC_DEC_REVERSE_EN.
package iiitb_jc_pkg;

  typedef logic [0:0] state_t;

  localparam state_t SEARCH = 1'b0;
  localparam state_t LOCKED = 1'b1;

  localparam int W_DEF      = 8;
  localparam int LOCK_N_DEF = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int GOOD_W     = 4;

  function automatic int ph_w(int w);
    return $clog2(2 * w);
  endfunction

endpackage

// File: rtl/iiitb_jc_phase_decode.sv
// Combinational Johnson code word to phase index decoder.
// Flags any word that is not one of the 2W legal codes.
module iiitb_jc_phase_decode
  import iiitb_jc_pkg::*;
#(
  parameter int W = W_DEF,
  localparam int PH_W = ph_w(W)
) (
  input  logic [W-1:0]    code_in,
  output logic            legal,
  output logic [PH_W-1:0] phase
);

  logic [W-1:0] v;
  logic [W-1:0] mask;

  // Upper half codes are the bitwise complement of a lower half code
  always_comb begin
    legal = 1'b0;
    phase = '0;
    v     = code_in[W-1] ? ~code_in : code_in;
    mask  = '0;
    for (int k = 0; k < W; k++) begin
      if (v == mask) begin
        legal = 1'b1;
        phase = code_in[W-1] ? PH_W'(W + k) : PH_W'(k);
      end
      mask = {mask[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iiitb_jc_decoder.sv
// Johnson code receiver: decode, successor check, lock FSM.
// Define JC_DEC_REVERSE_EN to accept reverse stepping.
module iiitb_jc_decoder
  import iiitb_jc_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int LOCK_N = LOCK_N_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int PH_W  = ph_w(W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [W-1:0]     code_in,
  output logic [PH_W-1:0]  phase,
  output logic             phase_valid,
  output logic             code_illegal,
  output logic             step_err,
  output logic             wrap,
  output logic             locked,
  output logic             dir,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [PH_W-1:0]   PH_MAX = PH_W'(2 * W - 1);
  localparam logic [GOOD_W-1:0] LOCK_G = GOOD_W'(LOCK_N);

  state_t              state;
  logic                prev_valid;
  logic [GOOD_W-1:0]   good_cnt;
  logic                legal;
  logic [PH_W-1:0]     dph;
  logic [PH_W-1:0]     nxt;
  logic [GOOD_W-1:0]   good_inc;
  logic [GOOD_W-1:0]   good_fwd;
  logic [CNT_W-1:0]    err_inc;
  logic                chk;
  logic                is_ill;
  logic                is_first;
  logic                is_hold;
  logic                is_fwd;
  logic                is_rev;
  logic                is_bad;

  iiitb_jc_phase_decode #(.W(W)) u_dec (
    .code_in (code_in),
    .legal   (legal),
    .phase   (dph)
  );

  assign nxt      = (phase == PH_MAX) ? '0 : phase + 1'b1;
  assign good_inc = (good_cnt == LOCK_G) ? good_cnt : good_cnt + 1'b1;
  assign err_inc  = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;

  assign chk      = code_valid & legal & prev_valid;
  assign is_ill   = code_valid & ~legal;
  assign is_first = code_valid & legal & ~prev_valid;
  assign is_hold  = chk & (dph == phase);
  assign is_fwd   = chk & ~is_hold & (dph == nxt);
  assign is_bad   = chk & ~is_hold & ~is_fwd & ~is_rev;

`ifdef JC_DEC_REVERSE_EN
  logic [PH_W-1:0]   prv;
  logic [GOOD_W-1:0] good_rev;
  logic              dir_q;

  assign prv      = (phase == '0) ? PH_MAX : phase - 1'b1;
  assign is_rev   = chk & ~is_hold & ~is_fwd & (dph == prv);
  // A direction change restarts the run of good steps at one
  assign good_fwd = dir_q ? GOOD_W'(1) : good_inc;
  assign good_rev = dir_q ? good_inc : GOOD_W'(1);
  assign dir      = dir_q;
`else
  assign is_rev   = 1'b0;
  assign good_fwd = good_inc;
  assign dir      = 1'b0;
`endif

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEARCH;
      prev_valid   <= 1'b0;
      good_cnt     <= '0;
      phase        <= '0;
      phase_valid  <= 1'b0;
      code_illegal <= 1'b0;
      step_err     <= 1'b0;
      wrap         <= 1'b0;
      err_cnt      <= '0;
`ifdef JC_DEC_REVERSE_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      phase_valid  <= 1'b0;
      code_illegal <= 1'b0;
      step_err     <= 1'b0;
      wrap         <= 1'b0;
      unique case (1'b1)
        is_ill: begin
          code_illegal <= 1'b1;
          err_cnt      <= err_inc;
          prev_valid   <= 1'b0;
          good_cnt     <= '0;
          state        <= SEARCH;
        end
        is_first: begin
          phase       <= dph;
          phase_valid <= 1'b1;
          prev_valid  <= 1'b1;
        end
        is_hold: begin
          phase_valid <= 1'b1;
        end
        is_fwd: begin
          phase       <= dph;
          phase_valid <= 1'b1;
          good_cnt    <= good_fwd;
          wrap        <= (phase == PH_MAX);
          if (good_fwd == LOCK_G) state <= LOCKED;
`ifdef JC_DEC_REVERSE_EN
          dir_q       <= 1'b0;
`endif
        end
`ifdef JC_DEC_REVERSE_EN
        is_rev: begin
          phase       <= dph;
          phase_valid <= 1'b1;
          good_cnt    <= good_rev;
          wrap        <= (phase == '0);
          dir_q       <= 1'b1;
          if (good_rev == LOCK_G) state <= LOCKED;
        end
`endif
        is_bad: begin
          phase       <= dph;
          phase_valid <= 1'b1;
          step_err    <= 1'b1;
          err_cnt     <= err_inc;
          good_cnt    <= '0;
          state       <= SEARCH;
        end
        default: ;
      endcase
    end
  end

endmodule
